// File: rtl/ben_cpu_pkg.sv
// ---------------------------------------------------------------------------
// ben_cpu_pkg
// Shared constants for the ben_cpu control path: opcode encodings, control
// word bit positions, microcode length and the canonical control words that
// the microcode ROM and the control unit assemble from those bits.
// No ports (package).
// ---------------------------------------------------------------------------
package ben_cpu_pkg;

  // Control word width and step counter sizing
  localparam int CTRL_W    = 16;
  localparam int NUM_STEPS = 5;
  localparam int STEP_W    = 3;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Opcodes (IR[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  // Control line bit positions
  localparam int CTL_HLT = 15;
  localparam int CTL_MI  = 14;
  localparam int CTL_RI  = 13;
  localparam int CTL_RO  = 12;
  localparam int CTL_IO  = 11;
  localparam int CTL_II  = 10;
  localparam int CTL_AI  = 9;
  localparam int CTL_AO  = 8;
  localparam int CTL_EO  = 7;
  localparam int CTL_SU  = 6;
  localparam int CTL_BI  = 5;
  localparam int CTL_OI  = 4;
  localparam int CTL_CE  = 3;
  localparam int CTL_CO  = 2;
  localparam int CTL_J   = 1;
  localparam int CTL_FI  = 0;

  // One-hot control word with a single line asserted
  function automatic ctrl_word_t ctl_bit(input int idx);
    ctl_bit = {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Microcode words used by the ROM
  localparam ctrl_word_t CW_NONE     = {CTRL_W{1'b0}};
  localparam ctrl_word_t CW_FETCH_PC = ctl_bit(CTL_CO) | ctl_bit(CTL_MI);
  localparam ctrl_word_t CW_FETCH_IR = ctl_bit(CTL_RO) | ctl_bit(CTL_II) | ctl_bit(CTL_CE);
  localparam ctrl_word_t CW_IR_MAR   = ctl_bit(CTL_IO) | ctl_bit(CTL_MI);
  localparam ctrl_word_t CW_RAM_A    = ctl_bit(CTL_RO) | ctl_bit(CTL_AI);
  localparam ctrl_word_t CW_RAM_B    = ctl_bit(CTL_RO) | ctl_bit(CTL_BI);
  localparam ctrl_word_t CW_ALU_ADD  = ctl_bit(CTL_EO) | ctl_bit(CTL_AI) | ctl_bit(CTL_FI);
  localparam ctrl_word_t CW_ALU_SUB  = CW_ALU_ADD | ctl_bit(CTL_SU);
  localparam ctrl_word_t CW_A_RAM    = ctl_bit(CTL_AO) | ctl_bit(CTL_RI);
  localparam ctrl_word_t CW_IR_A     = ctl_bit(CTL_IO) | ctl_bit(CTL_AI);
  localparam ctrl_word_t CW_JUMP     = ctl_bit(CTL_IO) | ctl_bit(CTL_J);
  localparam ctrl_word_t CW_A_OUT    = ctl_bit(CTL_AO) | ctl_bit(CTL_OI);
  localparam ctrl_word_t CW_HALT     = ctl_bit(CTL_HLT);

endpackage

// File: rtl/ben_microcode_rom.sv
// ---------------------------------------------------------------------------
// ben_microcode_rom
// Purely combinational microcode decode: (T-step, opcode, carry, zero) to the
// 16-bit control word. Halt override and sequencing live in the control unit.
// Ports:
//   i_step    [2:0]  current T-step (0..4)
//   i_opcode  [3:0]  IR[7:4]
//   i_flag_c         carry flag
//   i_flag_z         zero flag
//   o_ctrl    [15:0] control word for this step
// ---------------------------------------------------------------------------
module ben_microcode_rom
  import ben_cpu_pkg::*;
(
  input  logic [STEP_W-1:0] i_step,
  input  logic [3:0]        i_opcode,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output logic [CTRL_W-1:0] o_ctrl
);

  // Step/opcode decode; unlisted opcodes fall through to an empty word
  always_comb begin
    o_ctrl = CW_NONE;
    case (i_step)
      3'd0: o_ctrl = CW_FETCH_PC;
      3'd1: o_ctrl = CW_FETCH_IR;
      3'd2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: o_ctrl = CW_IR_MAR;
          OP_LDI:  o_ctrl = CW_IR_A;
          OP_JMP:  o_ctrl = CW_JUMP;
          OP_JC: begin
            if (i_flag_c) o_ctrl = CW_JUMP;
            else          o_ctrl = CW_NONE;
          end
          OP_JZ: begin
            if (i_flag_z) o_ctrl = CW_JUMP;
            else          o_ctrl = CW_NONE;
          end
          OP_OUT:  o_ctrl = CW_A_OUT;
          OP_HLT:  o_ctrl = CW_HALT;
          default: o_ctrl = CW_NONE;
        endcase
      end
      3'd3: begin
        case (i_opcode)
          OP_LDA:  o_ctrl = CW_RAM_A;
          OP_ADD, OP_SUB: o_ctrl = CW_RAM_B;
          OP_STA:  o_ctrl = CW_A_RAM;
          OP_HLT:  o_ctrl = CW_HALT;
          default: o_ctrl = CW_NONE;
        endcase
      end
      3'd4: begin
        case (i_opcode)
          OP_ADD:  o_ctrl = CW_ALU_ADD;
          OP_SUB:  o_ctrl = CW_ALU_SUB;
          OP_HLT:  o_ctrl = CW_HALT;
          default: o_ctrl = CW_NONE;
        endcase
      end
      default: o_ctrl = CW_NONE;
    endcase
  end

endmodule

// File: rtl/ben_control_unit.sv
// ---------------------------------------------------------------------------
// ben_control_unit
// Step-tick divider, 5-state T-step sequencer and halt latch for ben_cpu.
// The control word is decoded by ben_microcode_rom and overridden to HLT
// while halted.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_opcode  [3:0]   IR[7:4]
//   i_flag_c/_z       carry / zero flag registers
//   o_ctrl    [15:0]  control word (combinational from step/opcode/flags/halt)
//   o_tick            one-cycle step strobe (registered)
//   o_step    [2:0]   current T-step
//   o_halted          halt latch
// ---------------------------------------------------------------------------
module ben_control_unit
  import ben_cpu_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_opcode,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_tick,
  output logic [STEP_W-1:0] o_step,
  output logic              o_halted
);

  // CLK_DIV=1 still needs a 1-bit counter that simply stays at 0
  localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_HLT  = 3'd2;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [CTRL_W-1:0] rom_ctrl;

  // Step sequencing; a halt at T2 wins over the increment and freezes the step
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (tick_q && !halted_q) begin
      if ((step_q == STEP_HLT) && (i_opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else if (step_q == STEP_LAST) begin
        step_d = {STEP_W{1'b0}};
      end else begin
        step_d = step_q + 3'd1;
      end
    end else begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  // Divider; uses the next halt state so no tick escapes on the halting edge
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (halted_d) begin
      div_d  = div_q;
      tick_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d  = {DIV_W{1'b0}};
      tick_d = 1'b1;
    end else begin
      div_d  = div_q + DIV_W'(1);
      tick_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q    <= {DIV_W{1'b0}};
      tick_q   <= 1'b0;
      step_q   <= {STEP_W{1'b0}};
      halted_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  ben_microcode_rom u_rom (
    .i_step   (step_q),
    .i_opcode (i_opcode),
    .i_flag_c (i_flag_c),
    .i_flag_z (i_flag_z),
    .o_ctrl   (rom_ctrl)
  );

  assign o_ctrl   = halted_q ? CW_HALT : rom_ctrl;
  assign o_tick   = tick_q;
  assign o_step   = step_q;
  assign o_halted = halted_q;

endmodule

// File: doc/ben_control_unit.md
Name: ben_control_unit

Overview:
- Microcoded sequencer for the 8-bit ben_cpu datapath: PC, MAR, 16-byte RAM, IR, A/B registers, ALU, flags and OUT register.
- Generates a divided step tick and a 5-state T-step counter, and decodes the IR opcode plus flags into 16 one-hot control lines per step.
- Sits inside the mimasv2 top between the IR/flag registers and all bus drivers and loaders; it is the only source of bus control.

Parameters:
- CLK_DIV, 1, number of i_clk cycles per CPU step; must be >= 1. The top overrides it for visible LED speed.
- NUM_STEPS, 5, T-states per instruction (T0..T4), fixed microcode length.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_opcode  in  4  IR[7:4], live value from the datapath IR
- i_flag_c  in  1  carry flag register output
- i_flag_z  in  1  zero flag register output
- o_ctrl  out  16  control word. Bits: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI
- o_tick  out  1  one-cycle step strobe; datapath registers load only when o_tick=1
- o_step  out  3  current T-step, 0..4
- o_halted  out  1  halt latch

Behaviour:
- Reset values (async): div counter 0, o_tick 0, o_step 0, o_halted 0. While step 0 is held, o_ctrl=0x4004.
- Divider: counter counts 0..CLK_DIV-1 and wraps. o_tick is registered; it is 1 on the cycle after the counter reaches CLK_DIV-1 and 0 otherwise.
  - CLK_DIV=1: o_tick=1 on every cycle from the first post-reset edge.
  - CLK_DIV=4: o_tick is 1 for one cycle in every 4.
- Step counter: advances on each rising edge where o_tick=1. Sequence 0→1→2→3→4→0; it always runs all 5 steps, with no early termination.
- o_ctrl is combinational from (o_step, i_opcode, i_flag_c, i_flag_z, o_halted) and is stable for a whole step.
- Fetch steps, independent of opcode:
  - T0: CO|MI = 0x4004
  - T1: RO|II|CE = 0x1408
- Execute steps T2 / T3 / T4 (0 = no lines asserted):
  - 0000 NOP: 0 / 0 / 0
  - 0001 LDA: IO|MI 0x4800 / RO|AI 0x1200 / 0
  - 0010 ADD: 0x4800 / RO|BI 0x1020 / EO|AI|FI 0x0281
  - 0011 SUB: 0x4800 / 0x1020 / EO|AI|SU|FI 0x02C1
  - 0100 STA: 0x4800 / AO|RI 0x2100 / 0
  - 0101 LDI: IO|AI 0x0A00 / 0 / 0
  - 0110 JMP: IO|J 0x0802 / 0 / 0
  - 0111 JC: 0x0802 if i_flag_c else 0 / 0 / 0
  - 1000 JZ: 0x0802 if i_flag_z else 0 / 0 / 0
  - 1110 OUT: AO|OI 0x0110 / 0 / 0
  - 1111 HLT: HLT 0x8000
  - 1001–1101 (undefined): all steps 0, behaves as NOP
- Flags are sampled live during T2. The datapath guarantees they were updated only at a preceding FI tick.
- Halt:
  - At an o_tick edge with o_step=2 and opcode=1111, o_halted is set and o_step freezes at 2.
  - While o_halted=1: o_tick is forced to 0, the divider stops, and o_ctrl=0x8000.
  - Only i_rst clears the halt.
- Reset mid-instruction returns immediately to step 0. There is no partial completion; datapath state is the datapath's concern.
- Simultaneous events: the halt takes priority over the step increment on the same tick.

Decomposition:
- ben_cpu_pkg (shared) holds:
  - Opcode localparams (OP_NOP..OP_HLT).
  - Control bit index constants (CTL_HLT=15 .. CTL_FI=0).
  - NUM_STEPS.
  - A function or constant for the control word width (16).
- One natural sub-module, ben_microcode_rom: purely combinational decode of (step, opcode, c, z) → 16-bit word. The halt override and the sequencing stay in ben_control_unit.

Test Plan:
- CLK_DIV=1, release reset, opcode=0001 → o_ctrl on 5 consecutive cycles = 0x4004, 0x1408, 0x4800, 0x1200, 0x0000, then 0x4004 again; o_step=0,1,2,3,4,0.
- CLK_DIV=4, opcode=0011 → o_tick high exactly one cycle in 4; each o_ctrl value holds 4 cycles; T4 = 0x02C1.
- Opcode=0111, c=0 then c=1 across two instructions → T2 = 0x0000, then 0x0802. Repeat with JZ/z for the same results.
- Opcode=1111 → after the T2 tick, o_halted=1, o_step stays 2, o_ctrl=0x8000, o_tick=0 for 100 cycles; assert i_rst → o_halted=0, o_step=0, o_ctrl=0x4004.
- Assert i_rst asynchronously at step 3 of ADD, mid-cycle → o_step=0 immediately, without waiting for a clock edge; after release, the sequence restarts at 0x4004.
- Opcode=1010 (undefined) → T2..T4 o_ctrl=0x0000, no halt, step wraps normally.
